// File: rtl/guess_arbiter_if.sv
// Guess/result handshake between the arbiter (master) and the hangman controller (slave).
interface guess_arbiter_if;
  logic [4:0] g_letter;
  logic       g_player;
  logic       g_valid;
  logic       g_ready;
  logic       res_valid;
  logic       res_hit;

  modport master (
    output g_letter, g_player, g_valid,
    input  g_ready, res_valid, res_hit
  );

  modport slave (
    input  g_letter, g_player, g_valid,
    output g_ready, res_valid, res_hit
  );
endinterface

// File: rtl/guess_arbiter.sv
// Two-player guess arbiter: one-entry buffer per player, round-robin issue to the
// shared letter-compare datapath, then saturating per-player scoring from the result.
module guess_arbiter #(
  parameter int SCORE_W      = 4,
  parameter bit STRICT_TURNS = 1'b0,
  parameter bit DEDUP        = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         p0_letter,
  input  logic               p0_strobe,
  input  logic [4:0]         p1_letter,
  input  logic               p1_strobe,
  output logic               p0_busy,
  output logic               p1_busy,
  guess_arbiter_if.master    gif,
  input  logic               game_over,
  input  logic               new_game,
  output logic [SCORE_W-1:0] p0_score,
  output logic [SCORE_W-1:0] p1_score,
  output logic               turn,
  output logic               drop,
  output logic               invalid,
  output logic               dup_reject
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;
  localparam logic [4:0] MAX_CODE  = 5'd25;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [1:0]         buf_vld_q, buf_vld_d;
  logic [1:0][4:0]    buf_let_q, buf_let_d;
  logic [25:0]        mask_q, mask_d;
  logic [SCORE_W-1:0] score0_q, score0_d, score1_q, score1_d;
  logic               turn_q, turn_d;
  logic [4:0]         g_letter_q, g_letter_d;
  logic               g_player_q, g_player_d;
  logic               hit_q, hit_d;
  logic               drop_q, drop_d;
  logic               invalid_q, invalid_d;
  logic               dup_q, dup_d;

  logic [1:0]         stb;
  logic [1:0][4:0]    let_in;
  logic [1:0]         cons;
  logic               sel_vld, sel_player, sel_dup;
  logic [4:0]         sel_letter;

  assign stb       = {p1_strobe, p0_strobe};
  assign let_in[0] = p0_letter;
  assign let_in[1] = p1_letter;

  // Turn player first; the other player only fills an idle slot when turns are relaxed.
  always_comb begin
    sel_vld    = 1'b0;
    sel_player = turn_q;
    if (buf_vld_q[turn_q]) begin
      sel_vld    = 1'b1;
      sel_player = turn_q;
    end else if (!STRICT_TURNS && buf_vld_q[~turn_q]) begin
      sel_vld    = 1'b1;
      sel_player = ~turn_q;
    end
    sel_letter = buf_let_q[sel_player];
    sel_dup    = DEDUP && mask_q[sel_letter];
  end

  always_comb begin
    state_d    = state_q;
    buf_vld_d  = buf_vld_q;
    buf_let_d  = buf_let_q;
    mask_d     = mask_q;
    score0_d   = score0_q;
    score1_d   = score1_q;
    turn_d     = turn_q;
    g_letter_d = g_letter_q;
    g_player_d = g_player_q;
    hit_d      = hit_q;
    drop_d     = 1'b0;
    invalid_d  = 1'b0;
    dup_d      = 1'b0;
    cons       = 2'b00;

    case (state_q)
      IDLE: begin
        if (!game_over && sel_vld) begin
          if (sel_dup) begin
            cons[sel_player] = 1'b1;
            dup_d            = 1'b1;
          end else begin
            g_letter_d = sel_letter;
            g_player_d = sel_player;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        // An abort drops the in-flight guess entirely: no mask bit, no retry.
        if (game_over) begin
          cons[g_player_q] = 1'b1;
          state_d          = IDLE;
        end else if (gif.g_ready) begin
          cons[g_player_q]   = 1'b1;
          mask_d[g_letter_q] = 1'b1;
          state_d            = WAIT;
        end
      end
      WAIT: begin
        if (game_over) begin
          state_d = IDLE;
        end else if (gif.res_valid) begin
          hit_d   = gif.res_hit;
          state_d = UPDATE;
        end
      end
      default: begin
        if (hit_q && !g_player_q && score0_q != SCORE_MAX) score0_d = score0_q + SCORE_W'(1);
        if (hit_q &&  g_player_q && score1_q != SCORE_MAX) score1_d = score1_q + SCORE_W'(1);
        turn_d  = ~g_player_q;
        state_d = IDLE;
      end
    endcase

    // A slot freed this cycle can take a new strobe in the same cycle.
    for (int i = 0; i < 2; i++) begin
      if (cons[i]) buf_vld_d[i] = 1'b0;
      if (stb[i]) begin
        if (let_in[i] > MAX_CODE) begin
          invalid_d = 1'b1;
        end else if (buf_vld_q[i] && !cons[i]) begin
          drop_d = 1'b1;
        end else begin
          buf_vld_d[i] = 1'b1;
          buf_let_d[i] = let_in[i];
        end
      end
    end

    if (new_game) begin
      state_d    = IDLE;
      buf_vld_d  = '0;
      buf_let_d  = '0;
      mask_d     = '0;
      score0_d   = '0;
      score1_d   = '0;
      turn_d     = 1'b0;
      g_letter_d = '0;
      g_player_d = 1'b0;
      hit_d      = 1'b0;
      drop_d     = 1'b0;
      invalid_d  = 1'b0;
      dup_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_vld_q  <= '0;
      buf_let_q  <= '0;
      mask_q     <= '0;
      score0_q   <= '0;
      score1_q   <= '0;
      turn_q     <= 1'b0;
      g_letter_q <= '0;
      g_player_q <= 1'b0;
      hit_q      <= 1'b0;
      drop_q     <= 1'b0;
      invalid_q  <= 1'b0;
      dup_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_vld_q  <= buf_vld_d;
      buf_let_q  <= buf_let_d;
      mask_q     <= mask_d;
      score0_q   <= score0_d;
      score1_q   <= score1_d;
      turn_q     <= turn_d;
      g_letter_q <= g_letter_d;
      g_player_q <= g_player_d;
      hit_q      <= hit_d;
      drop_q     <= drop_d;
      invalid_q  <= invalid_d;
      dup_q      <= dup_d;
    end
  end

  assign gif.g_valid  = (state_q == ISSUE);
  assign gif.g_letter = g_letter_q;
  assign gif.g_player = g_player_q;
  assign p0_busy      = buf_vld_q[0];
  assign p1_busy      = buf_vld_q[1];
  assign p0_score     = score0_q;
  assign p1_score     = score1_q;
  assign turn         = turn_q;
  assign drop         = drop_q;
  assign invalid      = invalid_q;
  assign dup_reject   = dup_q;
endmodule
